// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant,
// per-grant hold limit, and a forced one-cycle bubble on every handoff.
module rr_arbiter_8 #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] grant,
  output logic         busy,
  output logic         timeout
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e           state_q;
  logic [2:0]       ptr_q;
  logic [2:0]       owner_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [N-1:0]     grant_q;
  logic             busy_q;
  logic             timeout_q;

  logic [2:0]       win_idx_d;
  logic             win_vld_d;
  logic [2:0]       cand;

  logic             rel_done;
  logic             rel_drop;
  logic             rel_limit;
  logic             release_now;

  // Scan from the farthest candidate to the nearest so the one closest to
  // ptr_q is the last (and therefore winning) assignment.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    win_vld_d = 1'b0;
    win_idx_d = ptr_q;
    cand      = ptr_q;
    for (int i = N - 1; i >= 0; i--) begin
      cand = ptr_q + i[2:0];
      if (req[cand]) begin
        win_vld_d = 1'b1;
        win_idx_d = cand;
      end
    end
  end

  assign rel_done    = done;
  assign rel_drop    = ~req[owner_q];
  assign rel_limit   = (hold_cnt_q == HOLD_LAST);
  assign release_now = rel_done | rel_drop | rel_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      state_q    <= S_IDLE;
      ptr_q      <= 3'd0;
      owner_q    <= 3'd0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_vld_d) begin
            state_q    <= S_GRANT;
            owner_q    <= win_idx_d;
            grant_q    <= N'(1) << win_idx_d;
            busy_q     <= 1'b1;
            hold_cnt_q <= '0;
          end
        end
        S_GRANT: begin
          if (release_now) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            ptr_q      <= owner_q + 3'd1;
            hold_cnt_q <= '0;
            // A limit hit only counts as a timeout when no normal release coincides.
            timeout_q  <= rel_limit & ~rel_done & ~rel_drop;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

  a_grant_onehot0 : assert property (@(posedge clk) $onehot0(grant_q));
  a_busy_matches  : assert property (@(posedge clk) busy_q == (|grant_q));
  a_timeout_pulse : assert property (@(posedge clk) disable iff (rst) timeout_q |=> !timeout_q);

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: each step pushes the expected post-edge
// outputs, and every scenario task pops and compares them against the DUT.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] grant;
  logic       busy;
  logic       timeout;

  typedef struct packed {
    logic [7:0] g;
    logic       b;
    logic       t;
  } obs_t;

  obs_t sb[$];
  obs_t seen[$];
  int   checks = 0;
  int   errors = 0;

  rr_arbiter_8 #(.N(8), .MAX_HOLD(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, record the expected and observed post-edge outputs.
  task automatic step(input logic r, input logic [7:0] rq, input logic d,
                      input logic [7:0] eg, input logic et);
    rst  = r;
    req  = rq;
    done = d;
    sb.push_back({eg, |eg, et});
    @(posedge clk);
    #1;
    seen.push_back({grant, busy, timeout});
  endtask

  task automatic test_reset();
    obs_t e, o;
    int   n = 0;
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hFF, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = seen.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset step %0d: got grant=%b busy=%b timeout=%b, want grant=%b busy=%b timeout=%b",
                 n, o.g, o.b, o.t, e.g, e.b, e.t);
      end
      n++;
    end
  endtask

  task automatic test_single();
    obs_t e, o;
    int   n = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h04, 1'b0, 8'h04, 1'b0);
    step(1'b0, 8'h04, 1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h09, 1'b0, 8'h08, 1'b0);
    step(1'b0, 8'h09, 1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = seen.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL single step %0d: got grant=%b busy=%b timeout=%b, want grant=%b busy=%b timeout=%b",
                 n, o.g, o.b, o.t, e.g, e.b, e.t);
      end
      n++;
    end
  endtask

  task automatic test_wrap();
    obs_t e, o;
    int   n = 0;
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h81, 1'b0, 8'h01, 1'b0);
    step(1'b0, 8'h81, 1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h81, 1'b0, 8'h80, 1'b0);
    step(1'b0, 8'h81, 1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h81, 1'b0, 8'h01, 1'b0);
    step(1'b0, 8'h81, 1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = seen.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap step %0d: got grant=%b busy=%b timeout=%b, want grant=%b busy=%b timeout=%b",
                 n, o.g, o.b, o.t, e.g, e.b, e.t);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t       e, o;
    int         n = 0;
    logic [7:0] one;
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 9; k++) begin
      one = 8'h01 << (k % 8);
      step(1'b0, 8'hFF, 1'b0, one, 1'b0);
      step(1'b0, 8'hFF, 1'b1, 8'h00, 1'b0);
    end
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = seen.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back step %0d: got grant=%b busy=%b timeout=%b, want grant=%b busy=%b timeout=%b",
                 n, o.g, o.b, o.t, e.g, e.b, e.t);
      end
      n++;
    end
  endtask

  // Enters with ptr=1 from the previous scenario.
  task automatic test_req_drop();
    obs_t e, o;
    int   n = 0;
    step(1'b0, 8'h02, 1'b0, 8'h02, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h06, 1'b0, 8'h04, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = seen.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL req_drop step %0d: got grant=%b busy=%b timeout=%b, want grant=%b busy=%b timeout=%b",
                 n, o.g, o.b, o.t, e.g, e.b, e.t);
      end
      n++;
    end
  endtask

  task automatic test_timeout();
    obs_t e, o;
    int   n = 0;
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    // Forced release after 16 visible cycles, then search resumes at bit 5.
    for (int i = 0; i < 16; i++) step(1'b0, 8'h10, 1'b0, 8'h10, 1'b0);
    step(1'b0, 8'h10, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h30, 1'b0, 8'h20, 1'b0);
    step(1'b0, 8'h30, 1'b1, 8'h00, 1'b0);
    // done on the 16th cycle: normal release, no timeout.
    for (int i = 0; i < 16; i++) step(1'b0, 8'h10, 1'b0, 8'h10, 1'b0);
    step(1'b0, 8'h10, 1'b1, 8'h00, 1'b0);
    // Dropped request on the 16th cycle: also a normal release.
    for (int i = 0; i < 16; i++) step(1'b0, 8'h10, 1'b0, 8'h10, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = seen.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL timeout step %0d: got grant=%b busy=%b timeout=%b, want grant=%b busy=%b timeout=%b",
                 n, o.g, o.b, o.t, e.g, e.b, e.t);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid_grant();
    obs_t e, o;
    int   n = 0;
    step(1'b0, 8'h20, 1'b0, 8'h20, 1'b0);
    step(1'b0, 8'h20, 1'b0, 8'h20, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'hFF, 1'b0, 8'h01, 1'b0);
    step(1'b0, 8'hFF, 1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = seen.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid_grant step %0d: got grant=%b busy=%b timeout=%b, want grant=%b busy=%b timeout=%b",
                 n, o.g, o.b, o.t, e.g, e.b, e.t);
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_req_drop();
    test_timeout();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
